// File: rtl/program_loader.sv
// program_loader: takes a byte-serial program image (base, length, data) from the host,
// writes it into program memory and keeps the CPU in sync reset until the image is complete.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN (adds a trailing checksum byte and err).
module program_loader #(
   parameter int PM_ADDR_W   = 8,
   parameter int HOLD_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 load_req,
   input  logic                 s_valid,
   input  logic [7:0]           s_data,
   output logic                 s_ready,
   output logic                 pm_wr_en,
   output logic [PM_ADDR_W-1:0] pm_wr_addr,
   output logic [7:0]           pm_wr_data,
   output logic                 cpu_sync_reset,
   output logic                 busy,
   output logic                 err,
   output logic [2:0]           state_dbg
);
   localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
   // A length byte of 0 means a full memory, capped at 256 bytes.
   localparam logic [8:0] LEN_ZERO = (PM_ADDR_W >= 8) ? 9'd256 : 9'(1 << PM_ADDR_W);

   typedef enum logic [2:0] {
      S_GET_ADDR = 3'd0,
      S_GET_LEN  = 3'd1,
      S_WRITE    = 3'd2,
      S_CHECK    = 3'd3,
      S_HOLD     = 3'd4,
      S_RUN      = 3'd5
   } state_t;

   state_t               state, state_nx;
   logic [PM_ADDR_W-1:0] base, index;
   logic [8:0]           remaining;
   logic [HC_W-1:0]      hold_cnt;
   logic                 xfer;
   logic                 wr_en_nx, cpu_rst_nx, busy_nx;
   logic [PM_ADDR_W-1:0] wr_addr_nx;
   logic [7:0]           wr_data_nx;

   // Handshake: a byte moves on a rising clk edge where s_valid && s_ready; s_ready depends
   // only on the state, and the host keeps s_data stable while s_valid is high and unaccepted.
   assign s_ready   = (state == S_GET_ADDR) || (state == S_GET_LEN) ||
                      (state == S_WRITE)    || (state == S_CHECK);
   assign xfer      = s_valid && s_ready;
   assign state_dbg = state;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0] sum, sum_chk;
   logic       err_nx;
   assign sum_chk = sum + s_data;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_GET_ADDR;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_GET_ADDR: if (xfer) state_nx = S_GET_LEN;
         S_GET_LEN:  if (xfer) state_nx = S_WRITE;
         S_WRITE: begin
            if (xfer && remaining == 9'd1) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               state_nx = S_CHECK;
`else
               state_nx = S_HOLD;
`endif
            end
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         S_CHECK:    if (xfer) state_nx = (sum_chk == 8'd0) ? S_HOLD : S_GET_ADDR;
`endif
         S_HOLD:     if (hold_cnt == HOLD_LAST) state_nx = S_RUN;
         S_RUN:      if (load_req) state_nx = S_GET_ADDR;
         default:    state_nx = S_GET_ADDR;
      endcase
   end

   // Registered outputs are computed from the next state so they line up with it.
   always_comb begin
      wr_en_nx   = (state == S_WRITE) && xfer;
      wr_addr_nx = wr_en_nx ? PM_ADDR_W'(base + index) : pm_wr_addr;
      wr_data_nx = wr_en_nx ? s_data : pm_wr_data;
      cpu_rst_nx = (state_nx != S_RUN);
      busy_nx    = (state_nx != S_RUN);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      err_nx = err;
      if (state == S_GET_ADDR && xfer)                    err_nx = 1'b0;
      else if (state == S_CHECK && xfer && sum_chk != 0)  err_nx = 1'b1;
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pm_wr_en       <= 1'b0;
         pm_wr_addr     <= '0;
         pm_wr_data     <= 8'd0;
         cpu_sync_reset <= 1'b1;
         busy           <= 1'b1;
      end else begin
         pm_wr_en       <= wr_en_nx;
         pm_wr_addr     <= wr_addr_nx;
         pm_wr_data     <= wr_data_nx;
         cpu_sync_reset <= cpu_rst_nx;
         busy           <= busy_nx;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base      <= '0;
         index     <= '0;
         remaining <= 9'd0;
         hold_cnt  <= '0;
      end else begin
         if (state == S_GET_ADDR && xfer) base <= PM_ADDR_W'(s_data);
         if (state == S_GET_LEN && xfer) begin
            remaining <= (s_data == 8'd0) ? LEN_ZERO : {1'b0, s_data};
            index     <= '0;
         end
         if (state == S_WRITE && xfer) begin
            remaining <= remaining - 9'd1;
            index     <= index + PM_ADDR_W'(1);
         end
         if (state == S_HOLD) hold_cnt <= hold_cnt + HC_W'(1);
         else                 hold_cnt <= '0;
      end
   end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   // The running sum covers address, length and every instruction byte.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum <= 8'd0;
         err <= 1'b0;
      end else begin
         err <= err_nx;
         if (state == S_GET_ADDR && xfer)                          sum <= s_data;
         else if ((state == S_GET_LEN || state == S_WRITE) && xfer) sum <= sum_chk;
      end
   end
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: random and directed images checked every cycle against a byte-counting
// model of the image format, plus literal expectations from the boot/wrap/reload scenarios.
module tb_program_loader;
   localparam int PM_ADDR_W   = 8;
   localparam int HOLD_CYCLES = 4;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic                 load_req;
   logic                 s_valid;
   logic [7:0]           s_data;
   logic                 s_ready;
   logic                 pm_wr_en;
   logic [PM_ADDR_W-1:0] pm_wr_addr;
   logic [7:0]           pm_wr_data;
   logic                 cpu_sync_reset;
   logic                 busy;
   logic                 err;
   logic [2:0]           state_dbg;

   program_loader #(.PM_ADDR_W(PM_ADDR_W), .HOLD_CYCLES(HOLD_CYCLES)) dut (
      .clk(clk), .reset_n(reset_n), .load_req(load_req), .s_valid(s_valid), .s_data(s_data),
      .s_ready(s_ready), .pm_wr_en(pm_wr_en), .pm_wr_addr(pm_wr_addr), .pm_wr_data(pm_wr_data),
      .cpu_sync_reset(cpu_sync_reset), .busy(busy), .err(err), .state_dbg(state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // An image is just a numbered byte stream: byte 0 is the base, byte 1 the length,
   // then the data bytes, then (optionally) the checksum byte.
   int         m_bytes = 0;
   int         m_len   = 0;
   int         m_hold  = 0;
   bit         m_run   = 0;
   bit         m_err   = 0;
   bit         m_wr_en = 0;
   bit         m_took  = 0;
   logic [7:0] m_base  = 0;
   logic [7:0] m_sum   = 0;
   logic [7:0] m_addr  = 0;
   logic [7:0] m_data  = 0;
   logic [15:0] exp_q[$];

   always @(posedge clk) begin
      logic [7:0] b;
      logic [7:0] tot;
      m_took  = 0;
      m_wr_en = 0;
      if (!reset_n) begin
         m_bytes = 0; m_len = 0; m_hold = 0; m_run = 0; m_err = 0;
         m_addr = 0; m_data = 0;
         exp_q.delete();
      end else if (m_run) begin
         if (load_req) m_run = 0;
      end else if (m_hold > 0) begin
         m_hold--;
         if (m_hold == 0) m_run = 1;
      end else if (s_valid) begin
         m_took = 1;
         b = s_data;
         if (m_bytes == 0) begin
            m_base = b; m_err = 0; m_sum = b;
            m_bytes = 1;
         end else if (m_bytes == 1) begin
            m_len = (b == 0) ? 256 : int'(b);
            m_sum = m_sum + b;
            m_bytes = 2;
         end else if (m_bytes < 2 + m_len) begin
            m_wr_en = 1;
            m_addr  = m_base + 8'(m_bytes - 2);
            m_data  = b;
            m_sum   = m_sum + b;
            exp_q.push_back({m_addr, m_data});
            m_bytes++;
            if (!CSUM && m_bytes == 2 + m_len) begin
               m_hold = HOLD_CYCLES; m_bytes = 0;
            end
         end else begin
            tot = m_sum + b;
            if (tot == 8'd0) m_hold = HOLD_CYCLES;
            else             m_err = 1;
            m_bytes = 0;
         end
      end
   end

   // ---------------- scoreboard / compare ----------------
   logic [15:0] wr_log[$];
   int          wr_cyc[$];
   int          fall_cyc = -1;
   logic        prev_cpu = 1'b1;

   always @(negedge clk) begin
      logic [15:0] e;
      cyc++;
      if (reset_n === 1'b1) begin
         chk("s_ready", s_ready, !m_run && m_hold == 0);
         chk("cpu_sync_reset", cpu_sync_reset, !m_run);
         chk("busy", busy, !m_run);
         chk("err", err, m_err);
         chk("pm_wr_en", pm_wr_en, m_wr_en);
         chk("pm_wr_addr", pm_wr_addr, m_addr);
         chk("pm_wr_data", pm_wr_data, m_data);
         if (pm_wr_en) begin
            wr_log.push_back({pm_wr_addr, pm_wr_data});
            wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) chk("wr_q_empty", pm_wr_en, 1'b0);
            else begin
               e = exp_q.pop_front();
               chk("wr_pair", {pm_wr_addr, pm_wr_data}, e);
            end
         end
      end
      if (prev_cpu && !cpu_sync_reset) fall_cyc = cyc;
      prev_cpu = cpu_sync_reset;
   end

   // ---------------- driver tasks ----------------
   logic [7:0] data_q[$];

   task automatic send_byte(input logic [7:0] b, input int gap, input bit lr);
      repeat (gap) begin
         s_valid = 1'b0;
         @(negedge clk);
      end
      s_valid  = 1'b1;
      s_data   = b;
      load_req = lr;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         load_req = 1'b0;
         if (m_took) return;
      end
      chk("accept_timeout", 32'd1, 32'd0);
   endtask

   task automatic send_image(input logic [7:0] base, input logic [7:0] len_b, input int gap_max,
                             input int lr_idx, input bit bad);
      logic [7:0] cs;
      cs = base + len_b;
      send_byte(base, $urandom_range(0, gap_max), 1'b0);
      send_byte(len_b, $urandom_range(0, gap_max), 1'b0);
      foreach (data_q[i]) begin
         cs = cs + data_q[i];
         send_byte(data_q[i], $urandom_range(0, gap_max), i == lr_idx);
      end
      if (CSUM) begin
         cs = 8'd0 - cs + {7'd0, bad};
         send_byte(cs, $urandom_range(0, gap_max), 1'b0);
      end
      s_valid = 1'b0;
   endtask

   task automatic wait_run();
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         #1;
         if (m_run) return;
      end
      chk("run_timeout", 32'd1, 32'd0);
   endtask

   task automatic reload();
      @(negedge clk);
      load_req = 1'b1;
      @(negedge clk);
      load_req = 1'b0;
   endtask

   task automatic do_reset();
      s_valid  = 1'b0;
      load_req = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("rst_pm_wr_en", pm_wr_en, 1'b0);
      chk("rst_state", state_dbg, 3'd0);
      chk("rst_cpu", cpu_sync_reset, 1'b1);
      chk("rst_busy", busy, 1'b1);
      chk("rst_s_ready", s_ready, 1'b1);
      chk("rst_err", err, 1'b0);
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b1;
   endtask

   task automatic fill_random(input int n);
      data_q.delete();
      for (int i = 0; i < n; i++) data_q.push_back(8'($urandom_range(0, 255)));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset_n = 1'b1; load_req = 1'b0; s_valid = 1'b0; s_data = 8'd0;
      do_reset();
      chk("rst_pm_wr_addr", pm_wr_addr, 8'd0);
      chk("rst_pm_wr_data", pm_wr_data, 8'd0);

      // Boot image, no gaps.
      wr_log.delete(); wr_cyc.delete();
      data_q = '{8'h81, 8'hC8, 8'hE0};
      send_image(8'h10, 8'h03, 0, -1, 1'b0);
      wait_run();
      chk("boot_n", wr_log.size(), 3);
      chk("boot_w0", wr_log[0], 16'h1081);
      chk("boot_w1", wr_log[1], 16'h11C8);
      chk("boot_w2", wr_log[2], 16'h12E0);
      chk("boot_consec", wr_cyc[2] - wr_cyc[0], 2);
      chk("boot_release", fall_cyc - wr_cyc[2], CSUM ? 5 : 4);
      chk("boot_busy", busy, 1'b0);

      // Address wrap.
      reload();
      wr_log.delete(); wr_cyc.delete();
      data_q = '{8'h11, 8'h22, 8'h33};
      send_image(8'hFE, 8'h03, 0, -1, 1'b0);
      wait_run();
      chk("wrap_n", wr_log.size(), 3);
      chk("wrap_w0", wr_log[0], 16'hFE11);
      chk("wrap_w1", wr_log[1], 16'hFF22);
      chk("wrap_w2", wr_log[2], 16'h0033);

      // Throttled boot image, s_valid held high through HOLD.
      reload();
      wr_log.delete(); wr_cyc.delete();
      data_q = '{8'h81, 8'hC8, 8'hE0};
      send_byte(8'h10, 3, 1'b0);
      send_byte(8'h03, 3, 1'b0);
      foreach (data_q[i]) send_byte(data_q[i], 3, 1'b0);
      if (CSUM) send_byte(8'd0 - (8'h10 + 8'h03 + 8'h81 + 8'hC8 + 8'hE0), 3, 1'b0);
      s_data = 8'hA5;
      repeat (12) @(negedge clk);
      #1;
      s_valid = 1'b0;
      chk("thr_n", wr_log.size(), 3);
      chk("thr_w0", wr_log[0], 16'h1081);
      chk("thr_w2", wr_log[2], 16'h12E0);
      chk("thr_release", fall_cyc - wr_cyc[2], CSUM ? 8 : 4);
      chk("thr_cpu", cpu_sync_reset, 1'b0);

      // Reload from RUN, then a load_req pulse during WRITE that must be ignored.
      reload();
      #1;
      chk("reload_cpu", cpu_sync_reset, 1'b1);
      chk("reload_ready", s_ready, 1'b1);
      wr_log.delete();
      fill_random(4);
      send_image(8'h30, 8'h04, 0, 1, 1'b0);
      wait_run();
      chk("lr_write_n", wr_log.size(), 4);

      // Random images with random gaps.
      for (int k = 0; k < 8; k++) begin
         int n;
         n = $urandom_range(1, 20);
         reload();
         wr_log.delete();
         fill_random(n);
         send_image(8'($urandom_range(0, 255)), 8'(n), 2, -1, 1'b0);
         wait_run();
         chk("rand_n", wr_log.size(), n);
      end

      // Reset in the middle of an image, then a complete reload.
      reload();
      send_byte(8'h40, 0, 1'b0);
      send_byte(8'h05, 0, 1'b0);
      send_byte(8'hAA, 0, 1'b0);
      send_byte(8'hBB, 0, 1'b0);
      do_reset();
      wr_log.delete();
      data_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      send_image(8'h40, 8'h05, 1, -1, 1'b0);
      wait_run();
      chk("mid_n", wr_log.size(), 5);
      chk("mid_w0", wr_log[0], 16'h4001);
      chk("mid_w4", wr_log[4], 16'h4405);

      // Length byte 0 loads all 256 locations.
      reload();
      wr_log.delete();
      fill_random(256);
      send_image(8'($urandom_range(0, 255)), 8'h00, 0, -1, 1'b0);
      wait_run();
      chk("len0_n", wr_log.size(), 256);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      reload();
      data_q = '{8'h05};
      send_image(8'h00, 8'h01, 0, -1, 1'b0);
      wait_run();
      chk("cs_good_cpu", cpu_sync_reset, 1'b0);
      reload();
      send_image(8'h00, 8'h01, 0, -1, 1'b1);
      repeat (6) @(negedge clk);
      #1;
      chk("cs_bad_err", err, 1'b1);
      chk("cs_bad_cpu", cpu_sync_reset, 1'b1);
      chk("cs_bad_ready", s_ready, 1'b1);
      data_q = '{8'h05};
      send_image(8'h00, 8'h01, 0, -1, 1'b0);
      wait_run();
      chk("cs_recover_err", err, 1'b0);
`endif

      repeat (3) @(negedge clk);
      chk("exp_q_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
